// File: rtl/disp_arb_pkg.sv
// Shared types and helpers for the display arbiter: FSM states, requester
// indices and the leading-zero blanking mask.
package disp_arb_pkg;

  typedef enum logic [1:0] {
    ST_SCORE = 2'd0,
    ST_MSG   = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int REQ_ALERT = 0;
  localparam int REQ_INFO  = 1;

  localparam logic [3:0] ENABLES_OFF = 4'b0000;

  // Bit 3 is the leftmost digit; the rightmost digit is always lit.
  function automatic logic [3:0] lz_mask(input logic [15:0] score);
    logic [3:0] m;
    m[3] = (score[15:12] != 4'd0);
    m[2] = m[3] | (score[11:8] != 4'd0);
    m[1] = m[2] | (score[7:4]  != 4'd0);
    m[0] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Request/display bundle between the message sources, the arbiter and the
// display multiplexer. The arbiter uses the slave modport.
interface display_arbiter_if;
  logic [15:0] score;
  logic [1:0]  msg_req;
  logic [15:0] msg0_data;
  logic [3:0]  msg0_mask;
  logic [15:0] msg1_data;
  logic [3:0]  msg1_mask;
  logic [1:0]  msg_ack;
  logic        busy;
  logic [3:0]  digit4;
  logic [3:0]  digit3;
  logic [3:0]  digit2;
  logic [3:0]  digit1;
  logic [1:4]  enables;

  modport master (
    output score, msg_req, msg0_data, msg0_mask, msg1_data, msg1_mask,
    input  msg_ack, busy, digit4, digit3, digit2, digit1, enables
  );

  modport slave (
    input  score, msg_req, msg0_data, msg0_mask, msg1_data, msg1_mask,
    output msg_ack, busy, digit4, digit3, digit2, digit1, enables
  );
endinterface

// File: rtl/disp_hold_timer.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module disp_hold_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)            cnt_q <= '0;
    else if (load)           cnt_q <= value;
    else if (cnt_q != '0)    cnt_q <= cnt_q - WIDTH'(1);
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/display_arbiter.sv
// Shares the 4-digit display between the live score and two timed messages
// (alert beats info). Optional alert blinking with DISP_ARB_BLINK_EN.
//
// state    | meaning
// ST_SCORE | score view with leading-zero blanking
// ST_MSG   | latched message shown for HOLD_TICKS cycles
// ST_GAP   | display blanked for GAP_TICKS cycles before returning
module display_arbiter
  import disp_arb_pkg::*;
#(
  parameter int HOLD_TICKS  = 50_000_000,
  parameter int GAP_TICKS   = 5_000_000,
  parameter int BLINK_TICKS = 12_500_000
) (
  input logic              clk,
  input logic              clear_n,
  display_arbiter_if.slave bus
);

  localparam int MAX_HG = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int MAX_T  = (MAX_HG > BLINK_TICKS) ? MAX_HG : BLINK_TICKS;
  localparam int TW     = $clog2(MAX_T + 1);

  state_t          state_q, state_d;
  logic [1:0]      accept, pick;
  logic            tmr_load, tmr_done;
  logic [TW-1:0]   tmr_value;

  logic [15:0]     data_q;
  logic [3:0]      mask_q;
  logic            src_info_q;
  logic [1:0]      acc_q;
  logic [3:0]      blink_gate;

  logic [15:0]     disp_q, disp_d;
  logic [3:0]      en_q, en_d;
  logic [1:0]      ack_q, ack_d;
  logic            busy_q, busy_d;

  assign pick = bus.msg_req[REQ_ALERT] ? 2'b01 : 2'b10;

  disp_hold_timer #(.WIDTH(TW)) u_timer (
    .clk     (clk),
    .clear_n (clear_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .done    (tmr_done)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= ST_SCORE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 2'b00;
    tmr_load  = 1'b0;
    tmr_value = TW'(HOLD_TICKS - 1);
    unique case (state_q)
      ST_SCORE: begin
        if (|bus.msg_req) begin
          accept   = pick;
          tmr_load = 1'b1;
          state_d  = ST_MSG;
        end
      end
      ST_MSG: begin
        // Only an info message can be preempted, and only by an alert.
        if (src_info_q && bus.msg_req[REQ_ALERT]) begin
          accept   = 2'b01;
          tmr_load = 1'b1;
        end else if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = TW'(GAP_TICKS - 1);
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          if (|bus.msg_req) begin
            accept   = pick;
            tmr_load = 1'b1;
            state_d  = ST_MSG;
          end else begin
            state_d  = ST_SCORE;
          end
        end
      end
      default: state_d = ST_SCORE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      data_q     <= '0;
      mask_q     <= '0;
      src_info_q <= 1'b0;
      acc_q      <= 2'b00;
    end else begin
      acc_q <= accept;
      if (accept[REQ_ALERT]) begin
        data_q     <= bus.msg0_data;
        mask_q     <= bus.msg0_mask;
        src_info_q <= 1'b0;
      end else if (accept[REQ_INFO]) begin
        data_q     <= bus.msg1_data;
        mask_q     <= bus.msg1_mask;
        src_info_q <= 1'b1;
      end
    end
  end

`ifdef DISP_ARB_BLINK_EN
  logic          phase_q;
  logic [TW-1:0] bcnt_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      phase_q <= 1'b1;
      bcnt_q  <= '0;
    end else if (accept[REQ_ALERT]) begin
      phase_q <= 1'b1;
      bcnt_q  <= TW'(BLINK_TICKS - 1);
    end else if (state_q == ST_MSG && !src_info_q) begin
      if (bcnt_q == '0) begin
        phase_q <= ~phase_q;
        bcnt_q  <= TW'(BLINK_TICKS - 1);
      end else begin
        bcnt_q  <= bcnt_q - TW'(1);
      end
    end
  end

  assign blink_gate = src_info_q ? 4'b1111 : {4{phase_q}};
`else
  assign blink_gate = 4'b1111;
`endif

  // Outputs follow state_q, so every view lags its source by one cycle.
  always_comb begin
    disp_d = disp_q;
    en_d   = ENABLES_OFF;
    ack_d  = acc_q;
    busy_d = (state_q != ST_SCORE);
    unique case (state_q)
      ST_SCORE: begin
        disp_d = bus.score;
        en_d   = lz_mask(bus.score);
      end
      ST_MSG: begin
        disp_d = data_q;
        en_d   = mask_q & blink_gate;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      disp_q <= '0;
      en_q   <= ENABLES_OFF;
      ack_q  <= 2'b00;
      busy_q <= 1'b0;
    end else begin
      disp_q <= disp_d;
      en_q   <= en_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
    end
  end

  assign bus.digit4  = disp_q[15:12];
  assign bus.digit3  = disp_q[11:8];
  assign bus.digit2  = disp_q[7:4];
  assign bus.digit1  = disp_q[3:0];
  assign bus.enables = en_q;
  assign bus.msg_ack = ack_q;
  assign bus.busy    = busy_q;

endmodule
